boot_fetch_ctrl: RTL
====================

BOOT_FETCH_CTRL -- requirements
Module: boot_fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 26: PC and memory address width.
REQ-002 SHALL have parameter DATA_W, default 32: instruction width.
REQ-003 SHALL have parameter BIOS_SIZE, default 41: number of valid BIOS words.
REQ-004 SHALL have parameter WDOG_LIMIT, default 65535: maximum number of cycles allowed in BIOS mode.
REQ-005 SHALL have port clock, input, 1: single clock; all state changes on the rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port pc, input, ADDR_W: current CPU program counter.
REQ-008 SHALL have port bios_instr, input, DATA_W: word returned by the BIOS ROM for bios_addr.
REQ-009 SHALL have port imem_instr, input, DATA_W: word returned by instruction memory for imem_addr.
REQ-010 SHALL have port halt, input, 1: the currently fetched instruction decodes as halt.
REQ-011 SHALL have ports sim_req (input, 1), sim_addr (input, ADDR_W) and sim_data (input, DATA_W): CPU request to store an instruction word.
REQ-012 SHALL have port sim_ack, output, 1: the store requested by sim_req completes this cycle.
REQ-013 SHALL have ports bios_addr (output, ADDR_W), imem_addr (output, ADDR_W), imem_we (output, 1) and imem_wdata (output, DATA_W).
REQ-014 SHALL have port instrucao, output, DATA_W: instruction delivered to decode.
REQ-015 SHALL have ports stall (output, 1), pc_clear (output, 1), boot_done (output, 1), fault (output, 1) and mode (output, 3): current state encoding.

Function
REQ-016 SHALL implement FSM states BOOT=0, BIOS=1, HANDOFF=2, USER=3, HALTED=4 and FAULT=5; mode SHALL equal the state.
REQ-017 BOOT SHALL last exactly 1 cycle with stall=1 and pc_clear=1, then go to BIOS.
REQ-018 In BIOS: bios_addr=pc; instrucao=bios_instr when pc<BIOS_SIZE, otherwise instrucao=0 and the next state is FAULT.
REQ-019 In BIOS, halt=1 SHALL go to HANDOFF; halt is ignored when pc>=BIOS_SIZE (FAULT takes priority).
REQ-020 A watchdog counter SHALL clear on entry to BIOS and increment each BIOS cycle; reaching WDOG_LIMIT SHALL go to FAULT.
REQ-021 HANDOFF SHALL last exactly 2 cycles with stall=1, pc_clear=1 and instrucao=0, then go to USER with boot_done=1.
REQ-022 In USER: imem_addr=pc and instrucao=imem_instr when no store is in progress.
REQ-023 In USER, halt=1 with no sim_req SHALL go to HALTED; halt is ignored during a cycle with stall=1.
REQ-024 HALTED and FAULT SHALL be terminal until reset, with stall=1 and instrucao=0; fault=1 only in FAULT.
REQ-025 Stores: when sim_req=1 in BIOS or USER, the block SHALL drive imem_addr=sim_addr, imem_wdata=sim_data, imem_we=1 and sim_ack=1 in the same cycle.
REQ-026 In USER, a store cycle SHALL force stall=1 and instrucao=0 because the port is shared; in BIOS, fetch is unaffected.
REQ-027 sim_req in BOOT, HANDOFF, HALTED or FAULT SHALL be ignored (imem_we=0, sim_ack=0).
REQ-028 When halt and sim_req are both high in USER, the store SHALL execute and halt SHALL be ignored; the CPU re-presents halt after the stall.
REQ-029 imem_addr SHALL equal pc whenever imem_we=0.

Reset
REQ-030 On reset low, the block SHALL asynchronously enter BOOT, clear the watchdog and HANDOFF counters, and clear boot_done.
REQ-031 During reset, outputs SHALL be: stall=1, pc_clear=1, imem_we=0, sim_ack=0, fault=0, instrucao=0 and addresses=0.
REQ-032 Reset asserted in any state, including mid-store or mid-HANDOFF, SHALL abort the operation with no partial write.

Structure
REQ-033 The state encoding, BIOS_SIZE, the handoff length (2) and the halt opcode (011000) SHALL live in a shared CPU package.
REQ-034 The watchdog SHALL be one sub-module, boot_watchdog, with a clear input, an enable input and an expire output.

Verification
REQ-035 Reset release, halt at pc=40 -> BOOT for 1 cycle, BIOS, HANDOFF for 2 cycles with pc_clear=1, then USER with boot_done=1.
REQ-036 In BIOS, pc=41 -> instrucao=0 and FAULT on the next edge, fault=1 held until reset.
REQ-037 In USER, sim_req with sim_addr=5 and sim_data=0xDEADBEEF -> same-cycle imem_we=1, sim_ack=1, imem_addr=5, stall=1; fetch resumes on the next cycle.
REQ-038 In USER, halt and sim_req both high -> store done and state stays USER; halt alone on the next cycle -> HALTED.
REQ-039 WDOG_LIMIT=8 and no halt in BIOS -> FAULT after exactly 8 BIOS cycles.
REQ-040 Reset asserted in the 2nd HANDOFF cycle -> immediate BOOT with boot_done=0 and no imem_we.

Source files
------------

// File: rtl/boot_fetch_ctrl_pkg.sv
// Shared CPU boot definitions: FSM state encoding, BIOS geometry, handoff length
// and the halt opcode.
package boot_fetch_ctrl_pkg;

    localparam int unsigned MODE_W        = 3;
    localparam int unsigned BIOS_SIZE_DEF = 41;
    localparam int unsigned HANDOFF_LEN   = 2;
    localparam int unsigned OPCODE_W      = 6;

    localparam logic [OPCODE_W-1:0] HALT_OPCODE = 6'b011000;

    typedef enum logic [MODE_W-1:0] {
        ST_BOOT    = 3'd0,
        ST_BIOS    = 3'd1,
        ST_HANDOFF = 3'd2,
        ST_USER    = 3'd3,
        ST_HALTED  = 3'd4,
        ST_FAULT   = 3'd5
    } state_e;

    // Opcode field sits in the top six bits of a 32-bit instruction word.
    function automatic logic is_halt_op(input logic [31:0] instr);
        return instr[31:26] == HALT_OPCODE;
    endfunction

endpackage : boot_fetch_ctrl_pkg

// File: rtl/boot_fetch_ctrl_if.sv
// Fetch/store bus between the CPU core, the BIOS ROM, instruction memory and
// the boot fetch controller.
interface boot_fetch_ctrl_if
    import boot_fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 26,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] bios_instr;
    logic [DATA_W-1:0] imem_instr;
    logic              halt;
    logic              sim_req;
    logic [ADDR_W-1:0] sim_addr;
    logic [DATA_W-1:0] sim_data;

    logic              sim_ack;
    logic [ADDR_W-1:0] bios_addr;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_we;
    logic [DATA_W-1:0] imem_wdata;
    logic [DATA_W-1:0] instrucao;
    logic              stall;
    logic              pc_clear;
    logic              boot_done;
    logic              fault;
    logic [MODE_W-1:0] mode;

    modport slave (
        input  pc, bios_instr, imem_instr, halt, sim_req, sim_addr, sim_data,
        output sim_ack, bios_addr, imem_addr, imem_we, imem_wdata, instrucao,
               stall, pc_clear, boot_done, fault, mode
    );

    modport master (
        output pc, bios_instr, imem_instr, halt, sim_req, sim_addr, sim_data,
        input  sim_ack, bios_addr, imem_addr, imem_we, imem_wdata, instrucao,
               stall, pc_clear, boot_done, fault, mode
    );

endinterface : boot_fetch_ctrl_if

// File: rtl/boot_fetch_ctrl_watchdog.sv
// BIOS watchdog: counts enabled cycles since the last clear and flags the cycle
// in which the LIMIT-th enabled cycle is being spent.
module boot_watchdog #(
    parameter int unsigned LIMIT = 65535
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expire_q, expire_d;

    // Saturate at LIMIT-1 so the flag stays up until the FSM leaves BIOS.
    always_comb begin : cnt_next
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        expire_d = (cnt_d == LAST);
    end

    always_ff @(posedge clock or negedge reset) begin : cnt_reg
        if (!reset) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    assign expire_o = expire_q;

endmodule : boot_watchdog

// File: rtl/boot_fetch_ctrl.sv
// Boot fetch controller: sequences BOOT -> BIOS -> HANDOFF -> USER, muxes the
// fetched instruction and arbitrates CPU stores onto the shared imem port.
module boot_fetch_ctrl
    import boot_fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = 26,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned BIOS_SIZE  = BIOS_SIZE_DEF,
    parameter int unsigned WDOG_LIMIT = 65535
) (
    input  logic             clock,
    input  logic             reset,
    boot_fetch_ctrl_if.slave bus
);

    localparam int unsigned HOFF_W = (HANDOFF_LEN > 1) ? $clog2(HANDOFF_LEN) : 1;
    localparam logic [HOFF_W-1:0] HOFF_LAST = HOFF_W'(HANDOFF_LEN - 1);

    state_e            state_q, state_d;
    logic [HOFF_W-1:0] hoff_cnt_q, hoff_cnt_d;
    logic              boot_done_q, boot_done_d;

    logic pc_in_bios_c;
    logic store_c;
    logic wdog_clear_c;
    logic wdog_en_c;
    logic wdog_expire;

    assign pc_in_bios_c = (bus.pc < ADDR_W'(BIOS_SIZE));
    assign store_c      = bus.sim_req && ((state_q == ST_BIOS) || (state_q == ST_USER));
    assign wdog_clear_c = (state_q == ST_BOOT);
    assign wdog_en_c    = (state_q == ST_BIOS);

    boot_watchdog #(
        .LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (wdog_clear_c),
        .en_i     (wdog_en_c),
        .expire_o (wdog_expire)
    );

    always_ff @(posedge clock or negedge reset) begin : state_reg
        if (!reset) begin
            state_q     <= ST_BOOT;
            hoff_cnt_q  <= '0;
            boot_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hoff_cnt_q  <= hoff_cnt_d;
            boot_done_q <= boot_done_d;
        end
    end

    // Out-of-range BIOS fetch and watchdog expiry both outrank a BIOS halt.
    always_comb begin : next_state
        state_d    = state_q;
        hoff_cnt_d = '0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_BIOS;
            end
            ST_BIOS: begin
                if (!pc_in_bios_c || wdog_expire) begin
                    state_d = ST_FAULT;
                end else if (bus.halt) begin
                    state_d = ST_HANDOFF;
                end
            end
            ST_HANDOFF: begin
                hoff_cnt_d = hoff_cnt_q + HOFF_W'(1);
                if (hoff_cnt_q == HOFF_LAST) begin
                    state_d = ST_USER;
                end
            end
            ST_USER: begin
                if (bus.halt && !bus.sim_req) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_FAULT;
        endcase
        boot_done_d = boot_done_q || (state_d == ST_USER);
    end

    always_comb begin : out_comb
        bus.mode       = state_q;
        bus.stall      = 1'b1;
        bus.pc_clear   = 1'b0;
        bus.boot_done  = boot_done_q;
        bus.fault      = 1'b0;
        bus.instrucao  = '0;
        bus.imem_we    = store_c;
        bus.sim_ack    = store_c;
        bus.imem_addr  = store_c ? bus.sim_addr : bus.pc;
        bus.imem_wdata = store_c ? bus.sim_data : '0;
        bus.bios_addr  = bus.pc;

        case (state_q)
            ST_BOOT, ST_HANDOFF: begin
                bus.pc_clear = 1'b1;
            end
            ST_BIOS: begin
                bus.stall = 1'b0;
                if (pc_in_bios_c) begin
                    bus.instrucao = bus.bios_instr;
                end
            end
            ST_USER: begin
                // A store owns the imem port for the cycle, so fetch must wait.
                if (!store_c) begin
                    bus.stall     = 1'b0;
                    bus.instrucao = bus.imem_instr;
                end
            end
            ST_FAULT: begin
                bus.fault = 1'b1;
            end
            default: begin
                bus.stall = 1'b1;
            end
        endcase

        // Held in reset: quiesce everything so an aborted store never reaches imem.
        if (!reset) begin
            bus.stall      = 1'b1;
            bus.pc_clear   = 1'b1;
            bus.boot_done  = 1'b0;
            bus.fault      = 1'b0;
            bus.instrucao  = '0;
            bus.imem_we    = 1'b0;
            bus.sim_ack    = 1'b0;
            bus.imem_addr  = '0;
            bus.imem_wdata = '0;
            bus.bios_addr  = '0;
        end
    end

endmodule : boot_fetch_ctrl
